// File: rtl/dds_spi_ctrl_pkg.sv
// Shared DDS-path constants: FSM encoding, timer defaults and serial word size.
package dds_spi_ctrl_pkg;

    // Timer compare value; one tick lasts TICK+2 system clocks.
    localparam logic [7:0] DDS_TICK_DEFAULT = 8'd3;

    // Largest compare value that still leaves room for the restart cycle.
    localparam logic [7:0] DDS_TICK_MAX = 8'd253;

    // Serial word length shifted to the DDS, MSB first.
    localparam int unsigned DDS_WORD_W_DEFAULT = 16;

    // Width of the count bus coming from the sibling dds_timer.
    localparam int unsigned DDS_COUNT_W = 8;

    // Frame sequencer states.
    typedef enum logic [2:0] {
        DDS_IDLE  = 3'd0,
        DDS_SETUP = 3'd1,
        DDS_SHIFT = 3'd2,
        DDS_HOLD  = 3'd3,
        DDS_DONE  = 3'd4
    } dds_state_e;

    // Number of system clocks dds_fsync stays low for one frame.
    function automatic int unsigned dds_frame_cycles(input int unsigned word_w,
                                                     input int unsigned tick);
        return (2 * word_w + 2) * (tick + 2);
    endfunction

endpackage

// File: rtl/dds_spi_ctrl.sv
// DDS serial-word controller: paces a WORD_W-bit, MSB-first frame on
// dds_sclk/dds_sdata/dds_fsync using ticks from an external dds_timer.
// The timer counts while state_start & state_over are high; this block
// drops state_over for one cycle on every tick to restart it.
module dds_spi_ctrl
    import dds_spi_ctrl_pkg::*;
#(
    parameter logic [7:0]  TICK   = DDS_TICK_DEFAULT,
    parameter int unsigned WORD_W = DDS_WORD_W_DEFAULT
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic              dds_start,
    input  logic [WORD_W-1:0] dds_word,
    input  logic [7:0]        count,
    output logic              state_start,
    output logic              state_over,
    output logic              dds_sclk,
    output logic              dds_sdata,
    output logic              dds_fsync,
    output logic              dds_busy,
    output logic              dds_done
);

    localparam int unsigned IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    dds_state_e        state_q, state_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              phase_q, phase_d;
    logic              sclk_q, sclk_d;
    logic              sdata_q, sdata_d;
    logic              fsync_q, fsync_d;
    logic              state_start_q, state_start_d;
    logic              state_over_q, state_over_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tick_c;

    // Tick: timer reached the compare value; anything beyond it (timer
    // fault) also counts so the frame always makes progress.
    always_comb begin
        tick_c = state_over_q && (count >= TICK);
    end

    // State and output registers; reset aborts any frame and drops the word.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q       <= DDS_IDLE;
            sreg_q        <= '0;
            idx_q         <= '0;
            phase_q       <= 1'b0;
            sclk_q        <= 1'b1;
            sdata_q       <= 1'b0;
            fsync_q       <= 1'b1;
            state_start_q <= 1'b0;
            state_over_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            sreg_q        <= sreg_d;
            idx_q         <= idx_d;
            phase_q       <= phase_d;
            sclk_q        <= sclk_d;
            sdata_q       <= sdata_d;
            fsync_q       <= fsync_d;
            state_start_q <= state_start_d;
            state_over_q  <= state_over_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_d       = state_q;
        sreg_d        = sreg_q;
        idx_d         = idx_q;
        phase_d       = phase_q;
        sclk_d        = sclk_q;
        sdata_d       = sdata_q;
        fsync_d       = fsync_q;
        state_start_d = state_start_q;
        state_over_d  = state_over_q;
        busy_d        = busy_q;
        done_d        = 1'b0;

        // Timer restart: one low cycle per tick, high again while framing.
        if (tick_c) begin
            state_over_d = 1'b0;
        end else if (state_start_q) begin
            state_over_d = 1'b1;
        end

        case (state_q)
            DDS_IDLE: begin
                if (dds_start) begin
                    sreg_d        = dds_word;
                    fsync_d       = 1'b0;
                    state_start_d = 1'b1;
                    state_over_d  = 1'b1;
                    busy_d        = 1'b1;
                    state_d       = DDS_SETUP;
                end
            end

            DDS_SETUP: begin
                if (tick_c) begin
                    sdata_d = sreg_q[WORD_W-1];
                    idx_d   = IDX_W'(WORD_W - 1);
                    phase_d = 1'b0;
                    state_d = DDS_SHIFT;
                end
            end

            DDS_SHIFT: begin
                if (tick_c) begin
                    if (!phase_q) begin
                        // Falling edge: DDS samples the bit already on sdata.
                        sclk_d  = 1'b0;
                        phase_d = 1'b1;
                    end else begin
                        // Rising edge: data only moves while sclk is high.
                        sclk_d  = 1'b1;
                        phase_d = 1'b0;
                        if (idx_q == '0) begin
                            state_d = DDS_HOLD;
                        end else begin
                            sreg_d  = {sreg_q[WORD_W-2:0], 1'b0};
                            sdata_d = sreg_q[WORD_W-2];
                            idx_d   = idx_q - IDX_W'(1);
                        end
                    end
                end
            end

            DDS_HOLD: begin
                if (tick_c) begin
                    state_start_d = 1'b0;
                    state_over_d  = 1'b0;
                    state_d       = DDS_DONE;
                end
            end

            DDS_DONE: begin
                // Frame closes here: fsync released together with the done pulse,
                // giving an fsync window of a whole number of tick periods.
                fsync_d = 1'b1;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = DDS_IDLE;
            end

            default: begin
                state_d = DDS_IDLE;
            end
        endcase
    end

    // Registered outputs.
    assign state_start = state_start_q;
    assign state_over  = state_over_q;
    assign dds_sclk    = sclk_q;
    assign dds_sdata   = sdata_q;
    assign dds_fsync   = fsync_q;
    assign dds_busy    = busy_q;
    assign dds_done    = done_q;

endmodule
